uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial receiver directly downstream of UART_TX: recovers frames from the TX_OUT line.
//  Frame format: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1); line idles high.
//  Oversamples each bit OVERSAMPLE times and takes a 3-sample majority vote at mid-bit.
//  Presents each received word as a parallel word with a 1-cycle valid strobe and per-frame error flags.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  OVERSAMPLE  8  CLK cycles per serial bit; even, >=4
// PORTS
//  CLK         in   1           single clock domain
//  RST         in   1           synchronous, active-high reset
//  RX_IN       in   1           serial line; may be asynchronous to CLK
//  PAR_EN      in   1           1: a parity bit follows the data
//  PAR_TYP     in   1           0: even parity, 1: odd parity
//  P_DATA      out  DATA_WIDTH  last good received word
//  DATA_VALID  out  1           1-cycle strobe; P_DATA holds a new good word
//  PAR_ERR     out  1           1-cycle strobe; parity mismatch
//  STP_ERR     out  1           1-cycle strobe; stop bit sampled 0
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge):
//   - Outputs go to 0, FSM goes to IDLE, counters clear, 2-flop synchronizer preset to 1.
//   - Applies mid-frame; the partial frame is discarded with no strobe.
//  Input path:
//   - RX_IN passes through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
//  Counters:
//   - edge_cnt runs 0..OVERSAMPLE-1 within a bit.
//   - Votes are taken at edge_cnt = H-1, H and H+1, where H = OVERSAMPLE/2.
//   - Bit value = majority of the 3 votes, resolved at edge_cnt = H+1.
//   - bit_cnt counts data bits 0..DATA_WIDTH-1.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//   - IDLE: on rx_s=0, go to START with edge_cnt=0.
//       - PAR_EN and PAR_TYP are latched here and are fixed for the whole frame.
//   - START, vote resolves 1: glitch; return to IDLE with no strobe.
//       - Vote 0: continue to DATA when edge_cnt=OVERSAMPLE-1.
//   - DATA: each resolved bit shifts in LSB first.
//       - After bit DATA_WIDTH-1 completes, go to PARITY if PAR_EN was latched, else STOP.
//   - PARITY: expected bit = ^data (even) or ~^data (odd). A mismatch sets an internal par_bad.
//   - STOP: evaluate at the stop-bit vote resolution; do not wait for the end of the bit.
//       - Next cycle: DATA_VALID=1 and P_DATA<=word only if the stop bit=1 and !par_bad.
//       - PAR_ERR=par_bad. STP_ERR=(stop bit==0). Both may assert together.
//       - Stop bit=1: go to IDLE. This rearms before the bit ends so back-to-back frames are caught.
//       - Stop bit=0: go to WAIT_HIGH.
//   - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low break line yields exactly one STP_ERR.
//  Latency:
//   - DATA_VALID asserts at (1+DATA_WIDTH+PAR_EN)*OVERSAMPLE + H + 2 cycles after IDLE sees rx_s=0.
//   - Add 2 cycles of synchronizer delay measured from RX_IN.
//  Output rules:
//   - P_DATA holds its value between good frames; errored frames never update it.
//   - Strobes are never asserted for more than 1 cycle per frame.
//   - A new frame's start edge may arrive 1 cycle after the strobe; it must be accepted.
// TESTING (OVERSAMPLE=8, DATA_WIDTH=8; bench drives RX_IN 8 CLKs per bit, idle high)
//  1. 0xAB, PAR_EN=1, PAR_TYP=0, parity=1, stop=1
//       -> single DATA_VALID, P_DATA=0xAB, PAR_ERR=STP_ERR=0.
//  2. 0x2A odd parity (parity=0), then 0x1F with PAR_EN=0 sent back-to-back, no idle gap
//       -> two DATA_VALID pulses, P_DATA 0x2A then 0x1F.
//  3. 0x55 even parity with the parity bit inverted
//       -> PAR_ERR pulse, no DATA_VALID, P_DATA keeps its previous value.
//  4. 0x3C with stop=0, line then held low for 20 bit times
//       -> one STP_ERR; no further strobes until the line goes high and a clean 0x3C arrives.
//  5. RX_IN low for 2 CLKs only (start glitch), then idle -> no strobes, FSM back in IDLE.
//  6. RST=1 for 1 cycle during data bit 3 of 0xF0
//       -> all outputs 0, no strobe; a following clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Serial receiver: majority-voted oversampling UART, parallel word out with per-frame error strobes.
// Latency: strobes assert (1+DATA_WIDTH+PAR_EN)*OVERSAMPLE + OVERSAMPLE/2 + 2 cycles after the synchronized start edge.
// Backpressure: none; strobes last one cycle and cannot be stalled, P_DATA holds until the next good word.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] VOTE0   = CW'(H - 1);
  localparam logic [CW-1:0] VOTE1   = CW'(H);
  localparam logic [CW-1:0] RESOLVE = CW'(H + 1);
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  logic                  rx_meta_q, rx_s_q;
  state_t                state_q, state_d;
  logic [CW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            vote_q, vote_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH:0]   shift_ext;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  bit_val;
  logic                  par_exp;

  // Two-flop synchronizer; preset high so a reset never looks like a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Third vote is the live sample at the resolve point; the first two were captured earlier.
  assign bit_val   = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
  assign par_exp   = par_typ_q ? ~^shift_q : ^shift_q;
  assign shift_ext = {bit_val, shift_q};

  // Frame FSM next-state, sampling counters and output strobes.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = (edge_cnt_q == OS_LAST) ? '0 : edge_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    vote_d     = vote_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (edge_cnt_q == VOTE0) vote_d[0] = rx_s_q;
    if (edge_cnt_q == VOTE1) vote_d[1] = rx_s_q;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        if (!rx_s_q) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (edge_cnt_q == RESOLVE && bit_val) begin
          // Start bit did not hold low through mid-bit: treat as a glitch.
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (edge_cnt_q == OS_LAST) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (edge_cnt_q == RESOLVE) shift_d = shift_ext[DATA_WIDTH:1];
        if (edge_cnt_q == OS_LAST) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (edge_cnt_q == RESOLVE) par_bad_d = (bit_val != par_exp);
        if (edge_cnt_q == OS_LAST) state_d = STOP;
      end
      STOP: begin
        // Decide at mid stop bit so the next start edge is never missed.
        if (edge_cnt_q == RESOLVE) begin
          edge_cnt_d = '0;
          se_d       = ~bit_val;
          pe_d       = par_bad_q;
          if (bit_val && !par_bad_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
          state_d = bit_val ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // A held-low break reports once; wait for the line to return to idle.
        edge_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame silently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      vote_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;

endmodule
